// File: rtl/outmux_dat_1_4.sv
// Return-path demux: routes one result beat to k1/k13/k15 by select code, with a
// two-entry (output + skid) buffer so that i_ready comes straight from a flop.
module outmux_dat_1_4 #(
  parameter int unsigned   DW      = 512,
  parameter int unsigned   SW      = 4,
  parameter logic [SW-1:0] SEL_K1  = SW'(1),
  parameter logic [SW-1:0] SEL_K13 = SW'(5),
  parameter logic [SW-1:0] SEL_K15 = SW'(7),
  parameter int unsigned   CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   i_dat,
  input  logic [SW-1:0]   i_sel,
  input  logic            i_valid,
  output logic            i_ready,
  output logic [DW-1:0]   o_k1_dat,
  output logic            o_k1_valid,
  input  logic            o_k1_ready,
  output logic [DW-1:0]   o_k13_dat,
  output logic            o_k13_valid,
  input  logic            o_k13_ready,
  output logic [DW-1:0]   o_k15_dat,
  output logic            o_k15_valid,
  input  logic            o_k15_ready,
  output logic            err,
  output logic [CNTW-1:0] err_cnt,
  output logic            busy
);

  logic            out_v_q, out_v_d;
  logic [DW-1:0]   out_dat_q, out_dat_d;
  logic [SW-1:0]   out_sel_q, out_sel_d;
  logic            skid_v_q, skid_v_d;
  logic [DW-1:0]   skid_dat_q, skid_dat_d;
  logic [SW-1:0]   skid_sel_q, skid_sel_d;
  logic            rdy_q, rdy_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] err_cnt_q, err_cnt_d;

  logic hit_k1, hit_k13, hit_k15;
  logic in_mapped, acc, acc_m, fire;

  assign in_mapped = (i_sel == SEL_K1) | (i_sel == SEL_K13) | (i_sel == SEL_K15);
  assign acc       = i_valid & rdy_q;
  assign acc_m     = acc & in_mapped;

  assign hit_k1  = out_v_q & (out_sel_q == SEL_K1);
  assign hit_k13 = out_v_q & (out_sel_q == SEL_K13);
  assign hit_k15 = out_v_q & (out_sel_q == SEL_K15);

  // Only the ready of the addressed port can retire the head beat.
  assign fire = (hit_k1 & o_k1_ready) | (hit_k13 & o_k13_ready) | (hit_k15 & o_k15_ready);

  always_comb begin
    out_v_d    = out_v_q;
    out_dat_d  = out_dat_q;
    out_sel_d  = out_sel_q;
    skid_v_d   = skid_v_q;
    skid_dat_d = skid_dat_q;
    skid_sel_d = skid_sel_q;
    err_d      = acc & ~in_mapped;
    err_cnt_d  = err_cnt_q;

    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end

    if (!out_v_q || fire) begin
      if (skid_v_q) begin
        out_v_d   = 1'b1;
        out_dat_d = skid_dat_q;
        out_sel_d = skid_sel_q;
        skid_v_d  = acc_m;
        if (acc_m) begin
          skid_dat_d = i_dat;
          skid_sel_d = i_sel;
        end
      end else begin
        out_v_d = acc_m;
        if (acc_m) begin
          out_dat_d = i_dat;
          out_sel_d = i_sel;
        end
      end
    end else if (acc_m) begin
      // Head is stalled; ready was high so the skid slot is free.
      skid_v_d   = 1'b1;
      skid_dat_d = i_dat;
      skid_sel_d = i_sel;
    end

    rdy_d = ~skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_v_q    <= 1'b0;
      out_dat_q  <= '0;
      out_sel_q  <= '0;
      skid_v_q   <= 1'b0;
      skid_dat_q <= '0;
      skid_sel_q <= '0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      out_v_q    <= out_v_d;
      out_dat_q  <= out_dat_d;
      out_sel_q  <= out_sel_d;
      skid_v_q   <= skid_v_d;
      skid_dat_q <= skid_dat_d;
      skid_sel_q <= skid_sel_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign i_ready     = rdy_q;
  assign o_k1_dat    = out_dat_q;
  assign o_k13_dat   = out_dat_q;
  assign o_k15_dat   = out_dat_q;
  assign o_k1_valid  = hit_k1;
  assign o_k13_valid = hit_k13;
  assign o_k15_valid = hit_k15;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = out_v_q | skid_v_q;

endmodule

// File: tb/tb_outmux_dat_1_4.sv
// Bench for outmux_dat_1_4: directed scenarios plus random traffic, all checked
// cycle by cycle against a two-deep in-order FIFO model of the return path.
module tb_outmux_dat_1_4;

  localparam int unsigned DW = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] i_dat;
  logic [3:0]    i_sel;
  logic          i_valid;
  logic          i_ready, s_ready;
  logic [DW-1:0] k1_dat, k13_dat, k15_dat, s_k1_dat, s_k13_dat, s_k15_dat;
  logic          k1_valid, k13_valid, k15_valid, s_k1_valid, s_k13_valid, s_k15_valid;
  logic          k1_ready, k13_ready, k15_ready;
  logic          err, s_err, busy, s_busy;
  logic [15:0]   err_cnt;
  logic [2:0]    s_err_cnt;

  always #5 clk = ~clk;

  outmux_dat_1_4 u_dut (
    .clk(clk), .reset(reset), .i_dat(i_dat), .i_sel(i_sel), .i_valid(i_valid),
    .i_ready(i_ready),
    .o_k1_dat(k1_dat), .o_k1_valid(k1_valid), .o_k1_ready(k1_ready),
    .o_k13_dat(k13_dat), .o_k13_valid(k13_valid), .o_k13_ready(k13_ready),
    .o_k15_dat(k15_dat), .o_k15_valid(k15_valid), .o_k15_ready(k15_ready),
    .err(err), .err_cnt(err_cnt), .busy(busy)
  );

  // Narrow counter instance so saturation is reachable in a few beats.
  outmux_dat_1_4 #(.CNTW(3)) u_sat (
    .clk(clk), .reset(reset), .i_dat(i_dat), .i_sel(i_sel), .i_valid(i_valid),
    .i_ready(s_ready),
    .o_k1_dat(s_k1_dat), .o_k1_valid(s_k1_valid), .o_k1_ready(k1_ready),
    .o_k13_dat(s_k13_dat), .o_k13_valid(s_k13_valid), .o_k13_ready(k13_ready),
    .o_k15_dat(s_k15_dat), .o_k15_valid(s_k15_valid), .o_k15_ready(k15_ready),
    .err(s_err), .err_cnt(s_err_cnt), .busy(s_busy)
  );

  typedef struct {
    logic [DW-1:0] dat;
    logic [3:0]    sel;
  } beat_t;

  beat_t       q[$];
  bit          rdy_m;
  bit          err_m;
  int unsigned cnt_m, cnt_s;
  bit          last_acc;
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got[63:0], exp[63:0]);
    end
  endtask

  function automatic bit is_mapped(input logic [3:0] s);
    return (s == 4'd1) || (s == 4'd5) || (s == 4'd7);
  endfunction

  function automatic bit port_ready(input logic [3:0] s);
    return (s == 4'd1) ? k1_ready : (s == 4'd5) ? k13_ready : k15_ready;
  endfunction

  function automatic logic [DW-1:0] rand_dat();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock: advance the model on the edge using pre-edge inputs, then compare.
  task automatic cycle();
    bit    fire;
    beat_t b;
    bit    head;
    @(posedge clk);
    last_acc = 1'b0;
    if (reset) begin
      q.delete();
      rdy_m = 1'b0;
      err_m = 1'b0;
      cnt_m = 0;
      cnt_s = 0;
    end else begin
      fire     = (q.size() > 0) && port_ready(q[0].sel);
      last_acc = i_valid && rdy_m;
      if (fire) void'(q.pop_front());
      if (last_acc && is_mapped(i_sel)) begin
        b.dat = i_dat;
        b.sel = i_sel;
        q.push_back(b);
      end
      err_m = last_acc && !is_mapped(i_sel);
      if (err_m && cnt_m < 16'hffff) cnt_m++;
      if (err_m && cnt_s < 7) cnt_s++;
      rdy_m = q.size() < 2;
    end
    #1;
    head = q.size() > 0;
    check_eq("i_ready", i_ready, rdy_m);
    check_eq("k1_valid", k1_valid, head && q[0].sel == 4'd1);
    check_eq("k13_valid", k13_valid, head && q[0].sel == 4'd5);
    check_eq("k15_valid", k15_valid, head && q[0].sel == 4'd7);
    check_eq("busy", busy, head);
    check_eq("err", err, err_m);
    check_eq("err_cnt", err_cnt, cnt_m);
    check_eq("sat_err_cnt", s_err_cnt, cnt_s);
    check_eq("sat_ready", s_ready, rdy_m);
    check_eq("sat_k1_valid", s_k1_valid, head && q[0].sel == 4'd1);
    if (head) begin
      check_eq("k1_dat", k1_dat, q[0].dat);
      check_eq("k13_dat", k13_dat, q[0].dat);
      check_eq("k15_dat", k15_dat, q[0].dat);
      if (s_k13_valid || s_k15_valid || s_err || s_busy) begin
        check_eq("sat_dat", (q[0].sel == 4'd1) ? s_k1_dat :
                            (q[0].sel == 4'd5) ? s_k13_dat : s_k15_dat, q[0].dat);
      end
    end
  endtask

  // Hold the current beat until the model accepts it, then drop i_valid.
  task automatic wait_acc();
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) check_eq("accept_timeout", 1'b0, 1'b1);
    i_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] s, input logic [DW-1:0] d);
    i_sel   = s;
    i_dat   = d;
    i_valid = 1'b1;
    wait_acc();
  endtask

  initial begin
    logic [3:0] bad_sel [6];
    logic [3:0] good_sel [3];
    bad_sel  = '{4'd0, 4'd2, 4'd3, 4'd9, 4'd12, 4'd15};
    good_sel = '{4'd1, 4'd5, 4'd7};

    // Reset with a beat already presented on k1.
    reset = 1'b1;
    i_valid = 1'b1; i_sel = 4'd1; i_dat = rand_dat();
    k1_ready = 1'b1; k13_ready = 1'b0; k15_ready = 1'b0;
    repeat (2) cycle();
    check_eq("rst_dat", k1_dat, '0);
    reset = 1'b0;
    wait_acc();
    cycle();

    // Streaming across ports, all readies high.
    k13_ready = 1'b1; k15_ready = 1'b1;
    i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_sel = (i == 0) ? 4'd5 : (i == 1) ? 4'd7 : (i == 2) ? 4'd1 : 4'd5;
      i_dat = DW'(i);
      cycle();
      check_eq("stream_acc", last_acc, 1'b1);
    end
    i_valid = 1'b0;
    repeat (3) cycle();

    // Stalled k15: head + skid fill, third beat waits.
    k15_ready = 1'b0;
    send(4'd7, rand_dat());
    send(4'd7, rand_dat());
    i_sel = 4'd7; i_dat = rand_dat(); i_valid = 1'b1;
    repeat (3) cycle();
    check_eq("skid_full_ready", i_ready, 1'b0);
    k15_ready = 1'b1;
    wait_acc();
    repeat (4) cycle();

    // Unmapped codes: two drops, then enough to saturate the narrow counter.
    send(4'd3, rand_dat());
    send(4'd0, rand_dat());
    cycle();
    check_eq("err_cnt_two", err_cnt, 16'd2);
    for (int i = 0; i < 8; i++) send(bad_sel[$urandom_range(0, 5)], rand_dat());
    cycle();
    check_eq("sat_hold", s_err_cnt, 3'd7);

    // Reset while two beats are buffered behind a stalled k1.
    k1_ready = 1'b0;
    send(4'd1, rand_dat());
    send(4'd1, rand_dat());
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_cnt", err_cnt, 16'd0);
    k1_ready = 1'b1;
    cycle();
    send(4'd1, rand_dat());
    repeat (3) cycle();

    // k13 held while the other readies are high.
    k13_ready = 1'b0;
    send(4'd5, rand_dat());
    repeat (10) cycle();
    check_eq("k13_hold", k13_valid, 1'b1);
    k13_ready = 1'b1;
    repeat (3) cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      i_valid   = ($urandom_range(0, 3) != 0);
      i_sel     = ($urandom_range(0, 4) == 0) ? bad_sel[$urandom_range(0, 5)]
                                              : good_sel[$urandom_range(0, 2)];
      i_dat     = rand_dat();
      k1_ready  = ($urandom_range(0, 3) != 0);
      k13_ready = ($urandom_range(0, 1) != 0);
      k15_ready = ($urandom_range(0, 4) != 0);
      reset     = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
